// File: rtl/mult_div_unit_pkg.sv
// Shared types and helpers for the multicycle multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } md_state_e;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/operand/result bundle between the control FSM (master) and the unit (slave).
// MULTDIV_UNSIGNED_EN adds the op_unsigned select.
interface mult_div_unit_if #(parameter int WIDTH = 32) ();
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_by_zero;
`ifdef MULTDIV_UNSIGNED_EN
    logic             op_unsigned;

    modport master (output start_mult, start_div, a, b, op_unsigned,
                    input  hi_out, lo_out, busy, done, div_by_zero);
    modport slave  (input  start_mult, start_div, a, b, op_unsigned,
                    output hi_out, lo_out, busy, done, div_by_zero);
`else
    modport master (output start_mult, start_div, a, b,
                    input  hi_out, lo_out, busy, done, div_by_zero);
    modport slave  (input  start_mult, start_div, a, b,
                    output hi_out, lo_out, busy, done, div_by_zero);
`endif
endinterface

// File: rtl/mult_div_unit_chk.sv
// Simulation checker: control must never pulse both starts in the same cycle.
module mult_div_unit_chk (
    input logic clk,
    input logic reset,
    input logic start_mult,
    input logic start_div
);

    a_one_start: assert property (@(posedge clk) disable iff (reset) !(start_mult && start_div))
        else $error("start_mult and start_div asserted together");

endmodule

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] trial_s;

    // Trial subtraction; rem < divisor keeps {rem,din} within WIDTH+1 bits.
    always_comb begin
        trial_s = {rem, din} - {1'b0, divisor};
        if (trial_s[WIDTH]) begin
            rem_next = {rem[WIDTH-2:0], din};
            qbit     = 1'b0;
        end else begin
            rem_next = trial_s[WIDTH-1:0];
            qbit     = 1'b1;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) producing HI and LO.
// Optional MULTDIV_UNSIGNED_EN adds multu/divu via op_unsigned.
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave md
);

    localparam int             CW       = clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    md_state_e        state_r, state_n;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   acc_r;        // Booth accumulator, or partial remainder when dividing
    logic [WIDTH-1:0] q_r;          // multiplier, or dividend/quotient shift register
    logic [WIDTH-1:0] m_r;          // multiplicand, or divisor magnitude
    logic             q1_r, uns_r, neg_q_r, neg_r_r;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             busy_r, done_r, dbz_r;

    logic             uns_in_s, a_neg_s, b_neg_s, last_s;
    logic             start_m_s, start_d_s, dbz_s;
    logic [WIDTH-1:0] a_abs_s, b_abs_s;
    logic [WIDTH:0]   m_ext_s, sum_s, acc_step_s;
    logic [WIDTH-1:0] q_step_s, rem_step_s, quo_step_s, quo_fix_s, rem_fix_s;
    logic             q1_step_s, qbit_s;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns_in_s = md.op_unsigned;
`else
    assign uns_in_s = 1'b0;
`endif

    assign a_neg_s = md.a[WIDTH-1] & ~uns_in_s;
    assign b_neg_s = md.b[WIDTH-1] & ~uns_in_s;
    assign a_abs_s = a_neg_s ? (~md.a + ONE_W) : md.a;
    assign b_abs_s = b_neg_s ? (~md.b + ONE_W) : md.b;
    assign last_s  = (cnt_r == CNT_LAST);

    // Multiply step: Booth add/subtract (signed) or shift-add (unsigned), then shift right.
    always_comb begin
        m_ext_s = uns_r ? {1'b0, m_r} : {m_r[WIDTH-1], m_r};
        sum_s   = acc_r;
        if (uns_r) begin
            if (q_r[0]) begin
                sum_s = acc_r + m_ext_s;
            end else begin
                sum_s = acc_r;
            end
        end else begin
            case ({q_r[0], q1_r})
                2'b01:   sum_s = acc_r + m_ext_s;
                2'b10:   sum_s = acc_r - m_ext_s;
                default: sum_s = acc_r;
            endcase
        end
        acc_step_s = {(uns_r ? 1'b0 : sum_s[WIDTH]), sum_s[WIDTH:1]};
        q_step_s   = {sum_s[0], q_r[WIDTH-1:1]};
        q1_step_s  = q_r[0];
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (acc_r[WIDTH-1:0]),
        .din      (q_r[WIDTH-1]),
        .divisor  (m_r),
        .rem_next (rem_step_s),
        .qbit     (qbit_s)
    );

    assign quo_step_s = {q_r[WIDTH-2:0], qbit_s};
    assign quo_fix_s  = neg_q_r ? (~quo_step_s + ONE_W) : quo_step_s;
    assign rem_fix_s  = neg_r_r ? (~rem_step_s + ONE_W) : rem_step_s;

    // Next-state logic; multiply wins if both starts arrive together.
    always_comb begin
        state_n   = state_r;
        start_m_s = 1'b0;
        start_d_s = 1'b0;
        dbz_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (md.start_mult) begin
                    state_n   = MULT;
                    start_m_s = 1'b1;
                end else if (md.start_div) begin
                    if (md.b == {WIDTH{1'b0}}) begin
                        state_n = FINISH;
                        dbz_s   = 1'b1;
                    end else begin
                        state_n   = DIV;
                        start_d_s = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            MULT, DIV: begin
                if (last_s) begin
                    state_n = FINISH;
                end else begin
                    state_n = state_r;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered outputs; HI/LO are written on the edge entering FINISH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {(WIDTH+1){1'b0}};
            q_r     <= {WIDTH{1'b0}};
            m_r     <= {WIDTH{1'b0}};
            q1_r    <= 1'b0;
            uns_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n == MULT) || (state_n == DIV);
            done_r  <= (state_n == FINISH);
            dbz_r   <= dbz_s;
            case (state_r)
                IDLE: begin
                    cnt_r <= {CW{1'b0}};
                    if (start_m_s) begin
                        acc_r <= {(WIDTH+1){1'b0}};
                        q_r   <= md.b;
                        m_r   <= md.a;
                        q1_r  <= 1'b0;
                        uns_r <= uns_in_s;
                    end else if (start_d_s) begin
                        acc_r   <= {(WIDTH+1){1'b0}};
                        q_r     <= a_abs_s;
                        m_r     <= b_abs_s;
                        uns_r   <= uns_in_s;
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                    end
                end
                MULT: begin
                    acc_r <= acc_step_s;
                    q_r   <= q_step_s;
                    q1_r  <= q1_step_s;
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        hi_r <= acc_step_s[WIDTH-1:0];
                        lo_r <= q_step_s;
                    end
                end
                DIV: begin
                    acc_r <= {1'b0, rem_step_s};
                    q_r   <= quo_step_s;
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        hi_r <= rem_fix_s;
                        lo_r <= quo_fix_s;
                    end
                end
                default: cnt_r <= {CW{1'b0}};
            endcase
        end
    end

    assign md.hi_out      = hi_r;
    assign md.lo_out      = lo_r;
    assign md.busy        = busy_r;
    assign md.done        = done_r;
    assign md.div_by_zero = dbz_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, HI/LO values, div-by-zero, reset abort.
module tb_mult_div_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mult_div_unit_if #(.WIDTH(32)) mdif ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdif)
    );

    mult_div_unit_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .start_mult (mdif.start_mult),
        .start_div  (mdif.start_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch an op in the current cycle T, then track done/busy and check results.
    task automatic run_op(input string tag, input logic is_div, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dbz);
        int   n;
        logic busy_bad;
        mdif.a          = av;
        mdif.b          = bv;
        mdif.start_mult = ~is_div;
        mdif.start_div  = is_div;
        step();
        mdif.start_mult = 1'b0;
        mdif.start_div  = 1'b0;
        mdif.a          = ~av;
        mdif.b          = 32'h0000_0001;
        n        = 1;
        busy_bad = 1'b0;
        while (mdif.done !== 1'b1 && n < 60) begin
            if (mdif.busy !== 1'b1) busy_bad = 1'b1;
            step();
            n++;
        end
        check_val({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check_val({tag, "_busy_during"}, {63'd0, busy_bad}, 64'd0);
        check_val({tag, "_busy_at_done"}, {63'd0, mdif.busy}, 64'd0);
        check_val({tag, "_hi"}, {32'd0, mdif.hi_out}, {32'd0, exp_hi});
        check_val({tag, "_lo"}, {32'd0, mdif.lo_out}, {32'd0, exp_lo});
        check_val({tag, "_dbz"}, {63'd0, mdif.div_by_zero}, {63'd0, exp_dbz});
        step();
        check_val({tag, "_done_pulse"}, {62'd0, mdif.done, mdif.div_by_zero}, 64'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        reset           = 1'b1;
        mdif.start_mult = 1'b0;
        mdif.start_div  = 1'b0;
        mdif.a          = 32'd0;
        mdif.b          = 32'd0;
`ifdef MULTDIV_UNSIGNED_EN
        mdif.op_unsigned = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        check_val("rst_hi", {32'd0, mdif.hi_out}, 64'd0);
        check_val("rst_lo", {32'd0, mdif.lo_out}, 64'd0);
        check_val("rst_flags", {61'd0, mdif.busy, mdif.done, mdif.div_by_zero}, 64'd0);

        run_op("mul_7_m3", 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("preload", 1'b1, 32'h0000_0451, 32'h0000_0020, 33, 32'h0000_0011, 32'h0000_0022, 1'b0);
        run_op("div_zero", 1'b1, 32'h0000_1234, 32'h0000_0000, 1, 32'h0000_0011, 32'h0000_0022, 1'b1);

        // Abort a multiply with reset while HI/LO hold nonzero values.
        mdif.a          = 32'h0000_0003;
        mdif.b          = 32'h0000_0005;
        mdif.start_mult = 1'b1;
        step();
        mdif.start_mult = 1'b0;
        for (int i = 0; i < 4; i++) step();
        mdif.b         = 32'h0000_0002;
        mdif.start_div = 1'b1;
        step();
        mdif.start_div = 1'b0;
        check_val("ign_div_busy", {63'd0, mdif.busy}, 64'd1);
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("abort_busy", {63'd0, mdif.busy}, 64'd0);
        check_val("abort_done", {63'd0, mdif.done}, 64'd0);
        check_val("abort_hi", {32'd0, mdif.hi_out}, 64'd0);
        check_val("abort_lo", {32'd0, mdif.lo_out}, 64'd0);
        run_op("mul_after_rst", 1'b0, 32'h1234_5678, 32'h0000_0010, 33, 32'h0000_0001, 32'h2345_6780, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
